// File: rtl/barrido_verdad_pkg.sv
// barrido_verdad_pkg
// Shared definitions for the barrido_verdad sweep-and-capture engine:
// controller state encoding, datapath widths and the number of codes swept.
package barrido_verdad_pkg;

  localparam int PAT_W  = 4;   // code width driven to the block under test
  localparam int RESP_W = 3;   // response width {x,y,z}
  localparam int ERR_W  = 5;   // mismatch counter, holds 0..16
  localparam int NCODES = 16;  // codes swept per run

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    FIN   = 2'd2
  } state_t;

endpackage

// File: rtl/barrido_tabla.sv
// barrido_tabla
// 16x3 capture table: one synchronous write port, one registered read port
// (1-cycle latency, old data on a same-edge read/write collision) and an
// asynchronous clear of every entry.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-high clear
//   we       in  write enable
//   wr_addr  in  write address (code being sampled)
//   wr_data  in  write data (sampled response)
//   rd_addr  in  read address
//   rd_data  out registered read data
import barrido_verdad_pkg::*;

module barrido_tabla (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PAT_W-1:0]  wr_addr,
  input  logic [RESP_W-1:0] wr_data,
  input  logic [PAT_W-1:0]  rd_addr,
  output logic [RESP_W-1:0] rd_data
);

  logic [RESP_W-1:0] mem [NCODES];

  // NOTE: the table is built from flops rather than a RAM macro precisely so
  // that every entry can be cleared by the asynchronous reset.
  // NOTE: non-blocking assignments make the read sample mem before this
  // edge's write lands, which is what gives old-data-on-collision behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCODES; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (we) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/barrido_verdad.sv
// barrido_verdad
// Sweep-and-capture engine for a 4-input / 3-output combinational block.
// Drives codes 0..15 in order, holding each for HOLD cycles, captures the
// response at the end of each hold window into barrido_tabla and, when
// CHECK_EN is set, counts mismatches against the EXPECTED truth table.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-high reset
//   start    in  start request, honoured only in IDLE
//   pat      out code to the block under test {a,b,c,d}
//   resp     in  response from the block under test {x,y,z}
//   busy     out high in DRIVE and FIN
//   done     out one-cycle pulse (FIN) when a sweep completes
//   pass     out last sweep had no mismatches (or checking disabled)
//   err_cnt  out mismatching codes in the current/last sweep
//   rd_addr  in  table read address
//   rd_data  out table entry at rd_addr, 1-cycle latency
import barrido_verdad_pkg::*;

module barrido_verdad #(
  parameter int                        HOLD     = 2,     // 1..255
  parameter logic [NCODES*RESP_W-1:0]  EXPECTED = '0,
  parameter bit                        CHECK_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [PAT_W-1:0]  pat,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  input  logic [PAT_W-1:0]  rd_addr,
  output logic [RESP_W-1:0] rd_data
);

  localparam logic [7:0]       HOLD_LAST = 8'(HOLD - 1);
  localparam logic [PAT_W-1:0] PAT_LAST  = PAT_W'(NCODES - 1);

  state_t            state, state_next;
  logic [7:0]        hold_cnt;
  logic              sample_fire;
  logic [RESP_W-1:0] exp_resp;
  logic              mismatch;

  // Last cycle of the hold window: the coming edge samples resp.
  assign sample_fire = (state == DRIVE) && (hold_cnt == HOLD_LAST);
  assign exp_resp    = EXPECTED[RESP_W*int'(pat) +: RESP_W];
  assign mismatch    = CHECK_EN && (resp != exp_resp);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  // NOTE: state_next is defaulted before the case so that no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DRIVE;
      DRIVE:   if (sample_fire && (pat == PAT_LAST)) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state == DRIVE) || (state == FIN);
    done = (state == FIN);
  end

  // Sweep datapath: code, hold counter, mismatch count and verdict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat      <= '0;
      hold_cnt <= '0;
      err_cnt  <= '0;
      pass     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pat      <= '0;
          hold_cnt <= '0;
          if (start) begin
            err_cnt <= '0;
            pass    <= 1'b0;
          end
        end
        DRIVE: begin
          if (sample_fire) begin
            hold_cnt <= '0;
            if (mismatch) err_cnt <= err_cnt + ERR_W'(1);
            // pat stays at 15 into FIN; it only wraps on the way back to IDLE
            if (pat != PAT_LAST) pat <= pat + PAT_W'(1);
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        FIN: begin
          pat  <= '0;
          // err_cnt already includes code 15, counted on the edge into FIN
          pass <= (err_cnt == '0) || !CHECK_EN;
        end
        default: begin
          pat      <= '0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  barrido_tabla u_tabla (
    .clk     (clk),
    .rst     (rst),
    .we      (sample_fire),
    .wr_addr (pat),
    .wr_data (resp),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule
